// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and default sizing for the SPI byte engine
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } spi_state_t;

  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 4;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - free-running half-period tick generator with synchronous clear
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - SPI mode-0 byte engine behind a start/ready/done handshake
// Optional build macro SPI_LOOPBACK_EN feeds the rx shift register from the internal mosi register.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int BW = $clog2(2 * DATA_W + 1);
  localparam logic [BW-1:0] LAST_HP   = BW'(2 * DATA_W - 1);
  localparam logic [BW-1:0] LAST_EVEN = BW'(2 * DATA_W - 2);

  spi_state_t        state, state_d;
  logic [BW-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0] tx_sh, tx_sh_d;
  logic [DATA_W-1:0] rx_sh, rx_sh_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              ready_d, done_d, sclk_d, mosi_d, cs_n_d;
  logic              tick, rx_in;

`ifdef SPI_LOOPBACK_EN
  // miso is deliberately masked out so the pin stays connected but has no effect
  assign rx_in = mosi | (miso & 1'b0);
`else
  assign rx_in = miso;
`endif

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_d != state),
    .tick (tick)
  );

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    tx_sh_d   = tx_sh;
    rx_sh_d   = rx_sh;
    rx_data_d = rx_data;
    ready_d   = ready;
    done_d    = 1'b0;
    sclk_d    = sclk;
    mosi_d    = mosi;
    cs_n_d    = cs_n;
    case (state)
      IDLE: begin
        ready_d = 1'b1;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        if (start) begin
          state_d = SETUP;
          tx_sh_d = tx_data;
          mosi_d  = tx_data[DATA_W-1];
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh[DATA_W-2:0], rx_in};
        end
      end
      SHIFT: begin
        // bit_cnt counts completed half-periods; an odd count means the next half is a rising one
        if (tick) begin
          if (bit_cnt == LAST_HP) begin
            state_d = HOLD;
            sclk_d  = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
            if (bit_cnt[0]) begin
              sclk_d  = 1'b1;
              rx_sh_d = {rx_sh[DATA_W-2:0], rx_in};
            end else begin
              sclk_d = 1'b0;
              if (bit_cnt != LAST_EVEN) begin
                tx_sh_d = tx_sh << 1;
                mosi_d  = tx_sh[DATA_W-2];
              end
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = DONE;
          done_d    = 1'b1;
          cs_n_d    = 1'b1;
          rx_data_d = rx_sh;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
    if (state_d != state) bit_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      tx_sh   <= tx_sh_d;
      rx_sh   <= rx_sh_d;
      rx_data <= rx_data_d;
      ready   <= ready_d;
      done    <= done_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      cs_n    <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb/tb_spi_byte_engine.sv - self-checking bench for spi_byte_engine (default and 16-bit/div-1 instances)
module tb_spi_byte_engine;

  localparam int LAT0 = 4 * (2 * 8 + 2) + 1;
  localparam int LAT1 = 1 * (2 * 16 + 2) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start0, ready0, done0, sclk0, mosi0, miso0, cs_n0;
  logic [7:0]  tx_data0, rx_data0;
  logic        start1, ready1, done1, sclk1, mosi1, miso1, cs_n1;
  logic [15:0] tx_data1, rx_data1;

  spi_byte_engine u0 (
    .clk(clk), .rst(rst), .start(start0), .tx_data(tx_data0), .ready(ready0), .done(done0),
    .rx_data(rx_data0), .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0)
  );

  spi_byte_engine #(.CLK_DIV(1), .DATA_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx_data1), .ready(ready1), .done(done1),
    .rx_data(rx_data1), .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Slave + observer for each instance: slave presents MSB first at cs_n fall, next bit after each sclk fall.
  logic [7:0]  sw0 = '0, mosi0_q = '0, rx0_at_done = '0;
  int done0_cnt = 0, done0_cyc = 0, rise0 = 0, fall0_cyc = 0, sidx0 = 0;
  logic p_sclk0 = 1'b0, p_cs0 = 1'b1;

  always @(negedge clk) begin
    if (done0) begin
      done0_cnt++;
      done0_cyc = cyc;
      rx0_at_done = rx_data0;
    end
    if (sclk0 && !p_sclk0) begin
      rise0++;
      mosi0_q = {mosi0_q[6:0], mosi0};
    end
    if (!cs_n0 && p_cs0) begin
      fall0_cyc = cyc;
      sidx0 = 7;
      miso0 = sw0[7];
    end else if (!sclk0 && p_sclk0 && !cs_n0 && sidx0 > 0) begin
      sidx0--;
      miso0 = sw0[sidx0];
    end
    p_sclk0 = sclk0;
    p_cs0 = cs_n0;
  end

  logic [15:0] sw1 = '0, mosi1_q = '0, rx1_at_done = '0;
  int done1_cnt = 0, done1_cyc = 0, rise1 = 0, sidx1 = 0;
  logic p_sclk1 = 1'b0, p_cs1 = 1'b1;

  always @(negedge clk) begin
    if (done1) begin
      done1_cnt++;
      done1_cyc = cyc;
      rx1_at_done = rx_data1;
    end
    if (sclk1 && !p_sclk1) begin
      rise1++;
      mosi1_q = {mosi1_q[14:0], mosi1};
    end
    if (!cs_n1 && p_cs1) begin
      sidx1 = 15;
      miso1 = sw1[15];
    end else if (!sclk1 && p_sclk1 && !cs_n1 && sidx1 > 0) begin
      sidx1--;
      miso1 = sw1[sidx1];
    end
    p_sclk1 = sclk1;
    p_cs1 = cs_n1;
  end

  function automatic logic [15:0] model_rx(input logic [15:0] tx, input logic [15:0] sw);
`ifdef SPI_LOOPBACK_EN
    return tx;
`else
    return sw;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready0(input string nm);
    int t = 0;
    while (!ready0 && t < 300) begin tick(); t++; end
    check({nm, " ready before start"}, ready0, 1);
  endtask

  task automatic wait_done0(input int n0, input string nm);
    int t = 0;
    while (done0_cnt == n0 && t < 300) begin tick(); t++; end
    check({nm, " done seen"}, done0_cnt, n0 + 1);
  endtask

  task automatic xfer0(input logic [7:0] tx, input logic [7:0] sw, input logic [7:0] exp_rx, input string nm);
    int c, n0;
    wait_ready0(nm);
    sw0 = sw; tx_data0 = tx; start0 = 1'b1;
    c = cyc; n0 = done0_cnt; rise0 = 0;
    tick();
    start0 = 1'b0;
    check({nm, " ready low after accept"}, ready0, 0);
    wait_done0(n0, nm);
    check({nm, " done latency"}, done0_cyc, c + LAT0);
    check({nm, " rx_data"}, rx0_at_done, exp_rx);
    check({nm, " mosi at rises"}, mosi0_q, tx);
    check({nm, " sclk rises"}, rise0, 8);
    tick();
    check({nm, " ready after done"}, ready0, 1);
    check({nm, " single done"}, done0_cnt, n0 + 1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sw;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c, n0, d1, t;
    logic [7:0] tx, sw;
    vecs[0] = '{8'hA5, 8'h3C, model_rx(16'hA5, 16'h3C)};
    vecs[1] = '{8'h5A, 8'hFF, model_rx(16'h5A, 16'hFF)};
    vecs[2] = '{8'h00, 8'h81, model_rx(16'h00, 16'h81)};
    vecs[3] = '{8'hFF, 8'h00, model_rx(16'hFF, 16'h00)};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; tx_data0 = '0; tx_data1 = '0; miso0 = 1'b0; miso1 = 1'b0;
    repeat (3) tick();
    check("reset ready", ready0, 1);
    check("reset done", done0, 0);
    check("reset rx_data", rx_data0, 0);
    check("reset sclk", sclk0, 0);
    check("reset mosi", mosi0, 0);
    check("reset cs_n", cs_n0, 1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) xfer0(vecs[i].tx, vecs[i].sw, vecs[i].exp_rx, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      tx = 8'($urandom); sw = 8'($urandom);
      xfer0(tx, sw, model_rx({8'h0, tx}, {8'h0, sw}), $sformatf("rand%0d", i));
    end

    // back-to-back with start held high
    wait_ready0("b2b");
    sw0 = 8'hC3; tx_data0 = 8'h01; start0 = 1'b1; n0 = done0_cnt;
    tick();
    wait_done0(n0, "b2b first");
    d1 = done0_cyc;
    check("b2b first rx", rx0_at_done, model_rx(16'h01, 16'hC3));
    check("b2b first mosi", mosi0_q, 8'h01);
    sw0 = 8'h96; tx_data0 = 8'h80;
    tick();
    check("b2b idle gap ready", ready0, 1);
    check("b2b idle gap cs_n", cs_n0, 1);
    tick();
    start0 = 1'b0;
    check("b2b cs_n fall", fall0_cyc, d1 + 2);
    wait_done0(n0 + 1, "b2b second");
    check("b2b second latency", done0_cyc, d1 + 1 + LAT0);
    check("b2b second rx", rx0_at_done, model_rx(16'h80, 16'h96));
    check("b2b second mosi", mosi0_q, 8'h80);

    // start pulsed while busy is ignored
    wait_ready0("busy");
    sw0 = 8'h4D; tx_data0 = 8'hC6; start0 = 1'b1; n0 = done0_cnt;
    tick();
    start0 = 1'b0;
    repeat (30) tick();
    tx_data0 = 8'hFF; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done0(n0, "busy");
    check("busy rx", rx0_at_done, model_rx(16'hC6, 16'h4D));
    check("busy mosi", mosi0_q, 8'hC6);
    repeat (150) tick();
    check("busy no second done", done0_cnt, n0 + 1);
    check("busy cs_n idle", cs_n0, 1);

    // reset at the 5th sclk rise, together with a start request
    wait_ready0("abort");
    sw0 = 8'h55; tx_data0 = 8'hAA; start0 = 1'b1; n0 = done0_cnt; rise0 = 0;
    tick();
    start0 = 1'b0;
    t = 0;
    while (rise0 < 5 && t < 200) begin tick(); t++; end
    check("abort reached 5th rise", rise0, 5);
    rst = 1'b1; start0 = 1'b1;
    tick();
    check("abort cs_n", cs_n0, 1);
    check("abort sclk", sclk0, 0);
    check("abort ready", ready0, 1);
    check("abort rx_data", rx_data0, 0);
    check("abort done", done0, 0);
    rst = 1'b0; start0 = 1'b0;
    tick();
    check("abort start dropped", cs_n0, 1);
    repeat (120) tick();
    check("abort no done", done0_cnt, n0);

`ifdef SPI_LOOPBACK_EN
    xfer0(8'h5A, 8'hFF, 8'h5A, "loopback");
`endif

    // 16-bit word at the fastest divider
    t = 0;
    while (!ready1 && t < 100) begin tick(); t++; end
    check("w16 ready", ready1, 1);
    sw1 = 16'($urandom); tx_data1 = 16'hBEEF; start1 = 1'b1;
    c = cyc; n0 = done1_cnt; rise1 = 0;
    tick();
    start1 = 1'b0;
    t = 0;
    while (done1_cnt == n0 && t < 100) begin tick(); t++; end
    check("w16 done seen", done1_cnt, n0 + 1);
    check("w16 latency", done1_cyc, c + LAT1);
    check("w16 rx_data", rx1_at_done, model_rx(16'hBEEF, sw1));
    check("w16 mosi", mosi1_q, 16'hBEEF);
    check("w16 rises", rise1, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
